// File: rtl/jsi_alu_pkg.sv
// Shared types and constants for the JSilicon sequential ALU front-end.
// MUL support is selected at build time with the JSI_ALU_MUL_EN macro.
package jsi_alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_CMP = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam int FLAG_Z    = 32'd0;
    localparam int FLAG_C    = 32'd1;
    localparam int FLAG_N    = 32'd2;
    localparam int MUL_ITERS = 32'd8;
    localparam int CNT_W     = 32'd3;

    function automatic logic [2:0] pack_flags(input logic n, input logic c, input logic z);
        logic [2:0] f;
        f         = 3'b000;
        f[FLAG_N] = n;
        f[FLAG_C] = c;
        f[FLAG_Z] = z;
        return f;
    endfunction

endpackage

// File: rtl/jsi_mul_shift.sv
// 8-cycle shift-add multiplier engine, only compiled when JSI_ALU_MUL_EN is defined.
// The multiplier rides in the low half of the accumulator and is consumed LSB first.
`ifdef JSI_ALU_MUL_EN
module jsi_mul_shift
    import jsi_alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  mcand,
    input  logic [7:0]  mplier,
    output logic [15:0] product,
    output logic        done
);
    logic [15:0]      acc_r;
    logic [7:0]       mcand_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;
    logic [7:0]       addend_s;
    logic [7:0]       sum_s;
    logic             carry_s;
    logic [15:0]      acc_nxt_s;

    sum_cell u_sum (
        .a (acc_r[15:8]),
        .b (addend_s),
        .s (sum_s)
    );

    // One iteration: conditional add into the upper half, keep the carry, shift right.
    always_comb begin
        addend_s  = 8'h00;
        if (acc_r[0]) begin
            addend_s = mcand_r;
        end else begin
            addend_s = 8'h00;
        end
        carry_s   = (({1'b0, acc_r[15:8]} + {1'b0, addend_s}) > 9'h0FF);
        acc_nxt_s = {carry_s, sum_s, acc_r[7:1]};
    end

    // The done pulse marks the cycle of the final iteration, so product is its result.
    assign done    = busy_r && (cnt_r == CNT_W'(MUL_ITERS - 1));
    assign product = acc_nxt_s;

    // Accumulator, multiplicand and iteration counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r   <= 16'h0000;
            mcand_r <= 8'h00;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
        end else if (start) begin
            acc_r   <= {8'h00, mplier};
            mcand_r <= mcand;
            cnt_r   <= '0;
            busy_r  <= 1'b1;
        end else if (busy_r) begin
            acc_r <= acc_nxt_s;
            cnt_r <= cnt_r + CNT_W'(1);
            if (done) begin
                busy_r <= 1'b0;
            end
        end
    end

endmodule
`endif

// File: rtl/minus_cell.sv
// Existing 8-bit subtractor cell; the borrow is recovered separately by its users.
module minus_cell (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] d
);
    assign d = a - b;
endmodule

// File: rtl/sum_cell.sv
// Existing 8-bit adder cell; the carry is recovered separately by its users.
module sum_cell (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] s
);
    assign s = a + b;
endmodule

// File: rtl/jsi_alu_seq.sv
// Sequential ALU front-end: ADD/SUB/CMP in one cycle, optional shift-add MUL
// (build macro JSI_ALU_MUL_EN), result held over a valid/ready handshake.
module jsi_alu_seq
    import jsi_alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_op,
    input  logic [7:0] in_a,
    input  logic [7:0] in_b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_res,
    output logic [7:0] out_hi,
    output logic [2:0] out_flags
);
    state_e     state_r;
    state_e     state_nxt_s;
    op_e        op_s;
    logic       accept_s;
    logic [7:0] sum_s;
    logic [7:0] diff_s;
    logic       carry_s;
    logic       borrow_s;
    logic       load_s;
    logic       valid_nxt_s;
    logic [7:0] res_nxt_s;
    logic [7:0] hi_nxt_s;
    logic [2:0] flags_nxt_s;
    logic       out_valid_r;
    logic [7:0] out_res_r;
    logic [7:0] out_hi_r;
    logic [2:0] out_flags_r;

    assign op_s     = op_e'(in_op);
    assign in_ready = (state_r == ST_IDLE);
    assign accept_s = in_valid && in_ready;

    sum_cell u_add (
        .a (in_a),
        .b (in_b),
        .s (sum_s)
    );

    minus_cell u_sub (
        .a (in_a),
        .b (in_b),
        .d (diff_s)
    );

    // Carry and borrow come from a parallel 9-bit view since the cells only give 8 bits.
    assign carry_s  = (({1'b0, in_a} + {1'b0, in_b}) > 9'h0FF);
    assign borrow_s = ({1'b0, in_a} < {1'b0, in_b});

`ifdef JSI_ALU_MUL_EN
    logic        mul_start_s;
    logic        mul_done_s;
    logic [15:0] mul_prod_s;

    assign mul_start_s = accept_s && (op_s == OP_MUL);

    jsi_mul_shift u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start_s),
        .mcand   (in_a),
        .mplier  (in_b),
        .product (mul_prod_s),
        .done    (mul_done_s)
    );
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
`ifdef JSI_ALU_MUL_EN
                    if (op_s == OP_MUL) begin
                        state_nxt_s = ST_MUL;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
`else
                    state_nxt_s = ST_DONE;
`endif
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
`ifdef JSI_ALU_MUL_EN
            ST_MUL: begin
                if (mul_done_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_MUL;
                end
            end
`endif
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output next values; result registers load only when a result is produced.
    always_comb begin
        load_s      = 1'b0;
        valid_nxt_s = out_valid_r;
        res_nxt_s   = out_res_r;
        hi_nxt_s    = out_hi_r;
        flags_nxt_s = out_flags_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    load_s      = 1'b1;
                    valid_nxt_s = 1'b1;
                    hi_nxt_s    = 8'h00;
                    case (op_s)
                        OP_ADD: begin
                            res_nxt_s   = sum_s;
                            flags_nxt_s = pack_flags(sum_s[7], carry_s, (sum_s == 8'h00));
                        end
                        OP_SUB: begin
                            res_nxt_s   = diff_s;
                            flags_nxt_s = pack_flags(diff_s[7], borrow_s, (diff_s == 8'h00));
                        end
                        OP_CMP: begin
                            res_nxt_s   = in_a;
                            flags_nxt_s = pack_flags(diff_s[7], borrow_s, (diff_s == 8'h00));
                        end
                        OP_MUL: begin
`ifdef JSI_ALU_MUL_EN
                            load_s      = 1'b0;
                            valid_nxt_s = 1'b0;
`else
                            res_nxt_s   = 8'h00;
                            flags_nxt_s = pack_flags(1'b0, 1'b0, 1'b1);
`endif
                        end
                        default: begin
                            load_s      = 1'b0;
                            valid_nxt_s = 1'b0;
                        end
                    endcase
                end else begin
                    valid_nxt_s = 1'b0;
                end
            end
`ifdef JSI_ALU_MUL_EN
            ST_MUL: begin
                if (mul_done_s) begin
                    load_s      = 1'b1;
                    valid_nxt_s = 1'b1;
                    res_nxt_s   = mul_prod_s[7:0];
                    hi_nxt_s    = mul_prod_s[15:8];
                    flags_nxt_s = pack_flags(mul_prod_s[15], (mul_prod_s[15:8] != 8'h00),
                                             (mul_prod_s == 16'h0000));
                end else begin
                    valid_nxt_s = 1'b0;
                end
            end
`endif
            ST_DONE: begin
                if (out_ready) begin
                    valid_nxt_s = 1'b0;
                end else begin
                    valid_nxt_s = 1'b1;
                end
            end
            default: begin
                valid_nxt_s = 1'b0;
            end
        endcase
    end

    // Registered result and flags, held stable while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_res_r   <= 8'h00;
            out_hi_r    <= 8'h00;
            out_flags_r <= 3'b000;
        end else begin
            out_valid_r <= valid_nxt_s;
            if (load_s) begin
                out_res_r   <= res_nxt_s;
                out_hi_r    <= hi_nxt_s;
                out_flags_r <= flags_nxt_s;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_res   = out_res_r;
    assign out_hi    = out_hi_r;
    assign out_flags = out_flags_r;

endmodule

// File: tb/tb_jsi_alu_seq.sv
// Self-checking bench for jsi_alu_seq: directed cases, backpressure, reset
// mid-operation and randomized ops against an arithmetic reference model.
module tb_jsi_alu_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_op;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_res;
    logic [7:0] out_hi;
    logic [2:0] out_flags;

    int checks = 0;
    int errors = 0;

`ifdef JSI_ALU_MUL_EN
    localparam int MUL_LAT = 8;
    localparam bit MUL_ON  = 1'b1;
`else
    localparam int MUL_LAT = 1;
    localparam bit MUL_ON  = 1'b0;
`endif

    jsi_alu_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_hi    (out_hi),
        .out_flags (out_flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model from the arithmetic rules: flags packed as {N, C, Z}.
    task automatic model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] res, output logic [7:0] hi, output logic [2:0] fl);
        int r;
        int p;
        bit n, c, z;
        hi = 8'h00;
        res = 8'h00;
        n = 1'b0; c = 1'b0; z = 1'b0;
        if (op == 2'd0) begin
            r   = int'(a) + int'(b);
            res = 8'(r % 256);
            c   = (r > 255);
            z   = (res == 8'h00);
            n   = (res >= 8'd128);
        end else if (op == 2'd2) begin
            if (MUL_ON) begin
                p   = int'(a) * int'(b);
                res = 8'(p % 256);
                hi  = 8'(p / 256);
                c   = (hi != 8'h00);
                z   = (p == 0);
                n   = (hi >= 8'd128);
            end else begin
                z = 1'b1;
            end
        end else begin
            r = int'(a) - int'(b);
            c = (a < b);
            z = (r == 0);
            n = (8'((r + 256) % 256) >= 8'd128);
            res = (op == 2'd1) ? 8'((r + 256) % 256) : a;
        end
        fl = {n, c, z};
    endtask

    // Present a request and return #1 after the edge that accepts it.
    task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("accept_timeout", {15'd0, in_ready}, 16'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                          input int hold);
        logic [7:0] er, eh;
        logic [2:0] ef;
        int lat;
        model(op, a, b, er, eh, ef);
        lat = (op == 2'd2 && MUL_ON) ? MUL_LAT : 1;
        send(op, a, b);
        for (int i = 1; i < lat; i++) begin
            @(posedge clk);
            #1;
            check("early_valid", {15'd0, out_valid}, 16'd0);
        end
        @(posedge clk);
        #1;
        check("valid", {15'd0, out_valid}, 16'd1);
        check("res", {8'd0, out_res}, {8'd0, er});
        check("hi", {8'd0, out_hi}, {8'd0, eh});
        check("flags", {13'd0, out_flags}, {13'd0, ef});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", {15'd0, out_valid}, 16'd1);
            check("hold_res", {out_hi, out_res}, {eh, er});
            check("hold_flags", {13'd0, out_flags}, {13'd0, ef});
            check("hold_ready", {15'd0, in_ready}, 16'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_valid", {15'd0, out_valid}, 16'd0);
        check("release_ready", {15'd0, in_ready}, 16'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] er, eh;
        logic [2:0] ef;
        logic [1:0] rop;
        logic [7:0] ra, rb;

        rst_n = 1'b0; in_valid = 1'b0; in_op = 2'd0; in_a = 8'h00; in_b = 8'h00;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {15'd0, in_ready}, 16'd1);
        check("rst_out_valid", {15'd0, out_valid}, 16'd0);
        check("rst_res_hi", {out_hi, out_res}, 16'h0000);
        check("rst_flags", {13'd0, out_flags}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed arithmetic cases, including flag boundaries.
        run_op(2'd0, 8'hF0, 8'h20, 0);
        run_op(2'd1, 8'h05, 8'h07, 0);
        run_op(2'd1, 8'h07, 8'h07, 2);
        run_op(2'd3, 8'h3C, 8'h3C, 0);
        run_op(2'd3, 8'h10, 8'h20, 1);
        run_op(2'd0, 8'hFF, 8'h01, 0);
        run_op(2'd0, 8'h00, 8'h00, 0);
        run_op(2'd2, 8'hFF, 8'hFF, 0);
        run_op(2'd2, 8'h00, 8'h5A, 1);
        run_op(2'd2, 8'h5A, 8'h01, 0);

        // Backpressure: a pending request must wait for the output handshake.
        send(2'd0, 8'h12, 8'h34);
        @(posedge clk);
        #1;
        check("bp_first_valid", {15'd0, out_valid}, 16'd1);
        check("bp_first_res", {8'd0, out_res}, 16'h0046);
        in_valid = 1'b1; in_op = 2'd1; in_a = 8'h50; in_b = 8'h10;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_valid", {15'd0, out_valid}, 16'd1);
            check("bp_hold_res", {out_hi, out_res}, 16'h0046);
            check("bp_hold_flags", {13'd0, out_flags}, 16'd0);
            check("bp_in_ready", {15'd0, in_ready}, 16'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_release_valid", {15'd0, out_valid}, 16'd0);
        check("bp_release_ready", {15'd0, in_ready}, 16'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        model(2'd1, 8'h50, 8'h10, er, eh, ef);
        check("bp_second_valid", {15'd0, out_valid}, 16'd1);
        check("bp_second_res", {out_hi, out_res}, {eh, er});
        check("bp_second_flags", {13'd0, out_flags}, {13'd0, ef});
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_second_release", {15'd0, out_valid}, 16'd0);

        // Reset in the middle of an operation discards it.
        if (MUL_ON) begin
            send(2'd2, 8'hAB, 8'hCD);
            repeat (4) @(posedge clk);
        end else begin
            send(2'd0, 8'hAB, 8'hCD);
            @(posedge clk);
        end
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", {15'd0, out_valid}, 16'd0);
        check("midrst_ready", {15'd0, in_ready}, 16'd1);
        check("midrst_res_hi", {out_hi, out_res}, 16'h0000);
        check("midrst_flags", {13'd0, out_flags}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("no_stale_valid", {15'd0, out_valid}, 16'd0);
        end
        run_op(2'd0, 8'h01, 8'h01, 0);

        // Randomized operations with random consumer stalls.
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            run_op(rop, ra, rb, int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
